// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter that drives the registered select of a C_INPUTS-way mux.
// Optional grant timeout and TIMEOUT output when MUX_SEL_TIMEOUT_EN is defined.
//
// Ports:
//   CLK      rising-edge clock
//   ACLR_N   asynchronous active-low reset
//   CE       clock enable (low freezes all state)
//   SCLR     synchronous clear, overrides CE
//   REQ      per-source level request
//   DONE     granted source releases the mux
//   S        registered binary select of the granted source
//   GNT      registered one-hot grant (zero when idle)
//   VALID    high while a grant is active
//   HOLD_CNT cycles elapsed in the current grant (saturating)
//   TIMEOUT  one-cycle pulse on a timeout release (MUX_SEL_TIMEOUT_EN only)
module mux_sel_rr_arbiter #(
  parameter int C_INPUTS     = 4,
  parameter int C_SEL_WIDTH  = 2,
  parameter int C_MAX_HOLD   = 8,
  parameter int C_HOLD_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    ACLR_N,
  input  logic                    CE,
  input  logic                    SCLR,
  input  logic [C_INPUTS-1:0]     REQ,
  input  logic                    DONE,
  output logic [C_SEL_WIDTH-1:0]  S,
  output logic [C_INPUTS-1:0]     GNT,
  output logic                    VALID,
`ifdef MUX_SEL_TIMEOUT_EN
  output logic                    TIMEOUT,
`endif
  output logic [C_HOLD_WIDTH-1:0] HOLD_CNT
);

  generate
    if ((C_INPUTS > (2 ** C_SEL_WIDTH)) || (C_INPUTS < 2)
        || (C_MAX_HOLD < 2)) begin : g_bad_param
      $error("mux_sel_rr_arbiter: bad parameters");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [C_SEL_WIDTH-1:0]  r_s;
  logic [C_SEL_WIDTH-1:0]  r_ptr;
  logic [C_INPUTS-1:0]     r_gnt;
  logic                    r_valid;
  logic [C_HOLD_WIDTH-1:0] r_hold;
  logic                    r_timeout;

  logic [C_INPUTS-1:0]     w_rot;
  logic [C_SEL_WIDTH-1:0]  w_pick;
  logic                    w_any;
  logic [C_SEL_WIDTH-1:0]  w_s_next;
  logic                    w_drop;
  logic                    w_tmo;
  logic                    w_release;
  logic [C_HOLD_WIDTH-1:0] w_hold_inc;

  // Requests rotated so bit 0 is the source at PTR.
  assign w_rot = C_INPUTS'({REQ, REQ} >> r_ptr);

  // First set bit of the rotated vector, mapped back to a source index.
  always_comb begin
    int v_idx;
    w_pick = '0;
    w_any  = 1'b0;
    v_idx  = 0;
    for (int k = C_INPUTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        v_idx = int'(r_ptr) + k;
        if (v_idx >= C_INPUTS) begin
          v_idx = v_idx - C_INPUTS;
        end
        w_pick = C_SEL_WIDTH'(v_idx);
        w_any  = 1'b1;
      end
    end
  end

  assign w_s_next = (r_s == C_SEL_WIDTH'(C_INPUTS - 1))
                  ? '0 : r_s + C_SEL_WIDTH'(1);

  // Owner dropped its request (GNT is the one-hot of S).
  assign w_drop = ~|(REQ & r_gnt);

`ifdef MUX_SEL_TIMEOUT_EN
  assign w_tmo = (r_hold == C_HOLD_WIDTH'(C_MAX_HOLD - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_release = DONE | w_drop | w_tmo;

  assign w_hold_inc = (&r_hold) ? r_hold : r_hold + C_HOLD_WIDTH'(1);

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else if (SCLR) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else if (CE) begin
      r_timeout <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_s     <= w_pick;
            r_gnt   <= C_INPUTS'(1) << w_pick;
            r_valid <= 1'b1;
            r_hold  <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_hold    <= '0;
            r_ptr     <= w_s_next;
            r_timeout <= w_tmo & ~DONE & ~w_drop;
          end else begin
            r_hold <= w_hold_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign S        = r_s;
  assign GNT      = r_gnt;
  assign VALID    = r_valid;
  assign HOLD_CNT = r_hold;
`ifdef MUX_SEL_TIMEOUT_EN
  assign TIMEOUT  = r_timeout;
`else
  logic w_unused;
  assign w_unused = r_timeout;
`endif

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: directed scenarios plus random stimulus
// against a behavioural model of the round-robin rules.
module tb_mux_sel_rr_arbiter;

  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int MH  = 8;
  localparam int HW  = 4;
  localparam int SAT = (1 << HW) - 1;
`ifdef MUX_SEL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          ACLR_N = 1'b0;
  logic          CE = 1'b0;
  logic          SCLR = 1'b0;
  logic [N-1:0]  REQ = '0;
  logic          DONE = 1'b0;
  logic [SW-1:0] S;
  logic [N-1:0]  GNT;
  logic          VALID;
  logic [HW-1:0] HOLD_CNT;
  logic          tmo_out;

  mux_sel_rr_arbiter #(
    .C_INPUTS(N), .C_SEL_WIDTH(SW),
    .C_MAX_HOLD(MH), .C_HOLD_WIDTH(HW)
  ) dut (
    .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR),
    .REQ(REQ), .DONE(DONE),
    .S(S), .GNT(GNT), .VALID(VALID),
`ifdef MUX_SEL_TIMEOUT_EN
    .TIMEOUT(tmo_out),
`endif
    .HOLD_CNT(HOLD_CNT)
  );

`ifndef MUX_SEL_TIMEOUT_EN
  assign tmo_out = 1'b0;
`endif

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference state
  bit m_busy;
  int m_s, m_ptr, m_cnt;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_s = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic m_edge(input logic [N-1:0] req, input bit done,
                        input bit ce, input bit sclr);
    bit rel_to, held;
    if (sclr) begin
      m_reset();
    end else if (ce) begin
      m_to = 0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_s = (m_ptr + k) % N;
            m_busy = 1; m_cnt = 0;
            break;
          end
        end
      end else begin
        held   = req[m_s];
        rel_to = TMO_EN && (m_cnt == MH - 1);
        if (done || !held || rel_to) begin
          m_busy = 0; m_cnt = 0;
          m_ptr = (m_s + 1) % N;
          m_to = rel_to && !done && held;
        end else begin
          m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".S"}, 32'(S), 32'(m_s));
    chk({tag, ".GNT"}, 32'(GNT), m_busy ? (32'd1 << m_s) : 32'd0);
    chk({tag, ".VALID"}, 32'(VALID), 32'(m_busy));
    chk({tag, ".HOLD"}, 32'(HOLD_CNT), 32'(m_cnt));
    chk({tag, ".TMO"}, 32'(tmo_out), 32'(m_to));
  endtask

  task automatic step(input string tag, input logic [N-1:0] req,
                      input bit done, input bit ce, input bit sclr);
    REQ = req; DONE = done; CE = ce; SCLR = sclr;
    @(posedge CLK);
    m_edge(req, done, ce, sclr);
    #1;
    cmp_all(tag);
  endtask

  task automatic async_rst(input string tag);
    #2 ACLR_N = 1'b0;
    #1;
    m_reset();
    cmp_all(tag);
    ACLR_N = 1'b1;
  endtask

  int grants[$];
  int exp_rot[5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] rreq;
  bit prev_v;

  initial begin
    m_reset();
    #3;
    cmp_all("rst");
    #4 ACLR_N = 1'b1;
    CE = 1'b1;

    // Rotation: all request, DONE on the cycle after each grant
    prev_v = 0;
    for (int i = 0; i < 12; i++) begin
      step("rot", 4'b1111, m_busy, 1, 0);
      if (VALID && !prev_v) grants.push_back(int'(S));
      prev_v = VALID;
    end
    chk("rot.n", 32'(grants.size()) >= 5 ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rot.seq", 32'(grants[i]), 32'(exp_rot[i]));

    // Async reset mid-grant with S=2, then REQ 0 wins
    step("clr", 4'b0000, 0, 1, 1);
    step("g2", 4'b0100, 0, 1, 0);
    step("g2", 4'b0100, 0, 1, 0);
    chk("g2.S", 32'(S), 32'd2);
    async_rst("arst");
    step("arst2", 4'b0101, 0, 1, 0);
    chk("arst.S0", 32'(S), 32'd0);
    step("arst3", 4'b0101, 1, 1, 0);

    // REQ drop at HOLD_CNT=3
    step("clr", 4'b0000, 0, 1, 1);
    step("d1", 4'b0010, 0, 1, 0);
    chk("drop.S1", 32'(S), 32'd1);
    for (int i = 0; i < 3; i++) step("d1", 4'b0010, 0, 1, 0);
    chk("drop.h3", 32'(HOLD_CNT), 32'd3);
    step("drop", 4'b0001, 0, 1, 0);
    chk("drop.v", 32'(VALID), 32'd0);
    step("drop2", 4'b0011, 0, 1, 0);
    chk("drop.S0", 32'(S), 32'd0);

    // CE freeze, then SCLR while CE low
    for (int i = 0; i < 2; i++) step("ce", 4'b0011, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("frz", 4'b0011, 1, 0, 0);
    chk("frz.v", 32'(VALID), 32'd1);
    step("sclr", 4'b0011, 0, 0, 1);
    chk("sclr.v", 32'(VALID), 32'd0);
    chk("sclr.S", 32'(S), 32'd0);

    // Long grant without DONE
    step("clr", 4'b0000, 0, 1, 1);
    for (int i = 0; i < 20; i++) step("long", 4'b0100, 0, 1, 0);
`ifndef MUX_SEL_TIMEOUT_EN
    chk("long.sat", 32'(HOLD_CNT), 32'd15);
    chk("long.v", 32'(VALID), 32'd1);
`endif

    // Random traffic
    step("clr", 4'b0000, 0, 1, 1);
    rreq = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      step("rnd", rreq,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) == 0);
      chk("rnd.Srange", 32'(S) < N ? 32'd1 : 32'd0, 32'd1);
      if (i % 400 == 399) async_rst("rnd.arst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
